// File: rtl/viz_frame_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// viz_pkg : shared screen geometry, FSM states and palette for the bar-graph
//           frame scheduler.                                   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package viz_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK        = 3'b000;
  localparam logic [COLOUR_W-1:0] PALETTE_BASE = 3'b001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LATCH = 3'd2,
    DRAW  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/viz_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// viz_frame_scheduler_if : amplitude/tick inputs and pixel-plot outputs of the
//                          frame scheduler.                    Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface viz_frame_scheduler_if
  import viz_pkg::*;
#(
  parameter int NUM_BANDS = 6,
  parameter int AMP_W     = 4
);

  logic                       start;
  logic                       sample_valid;
  logic [NUM_BANDS*AMP_W-1:0] amp_freq;
  logic                       frame_tick;
  logic                       plot;
  logic [X_W-1:0]             x;
  logic [Y_W-1:0]             y;
  logic [COLOUR_W-1:0]        colour;
  logic                       busy;
  logic                       frame_done;

  modport master (
    output start, sample_valid, amp_freq, frame_tick,
    input  plot, x, y, colour, busy, frame_done
  );

  modport slave (
    input  start, sample_valid, amp_freq, frame_tick,
    output plot, x, y, colour, busy, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/viz_frame_scheduler_raster_scan_counter.sv
// ----------------------------------------------------------------------------
// raster_scan_counter : x-inner / y-outer raster counter with a per-bar column
//                       counter that yields the band index without a divider.
//                                                              Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module raster_scan_counter
  import viz_pkg::*;
#(
  parameter int BAR_W  = 24,
  parameter int BAND_W = 3
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              enable,
  input  wire logic              clear,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [BAND_W-1:0]      band_idx,
  output logic                   last_pixel
);

  localparam int c_col_w = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [BAND_W-1:0]  r_band;
  logic [c_col_w-1:0] r_col;

  logic w_x_last;
  logic w_y_last;
  logic w_col_last;

  assign w_x_last   = (r_x == X_W'(SCREEN_W - 1));
  assign w_y_last   = (r_y == Y_W'(SCREEN_H - 1));
  assign w_col_last = (r_col == c_col_w'(BAR_W - 1));

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      r_x    <= '0;
      r_y    <= '0;
      r_band <= '0;
      r_col  <= '0;
    end else if (enable) begin
      if (w_x_last) begin
        r_x    <= '0;
        r_col  <= '0;
        r_band <= '0;
        r_y    <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
        if (w_col_last) begin
          r_col  <= '0;
          r_band <= r_band + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign band_idx   = r_band;
  assign last_pixel = w_x_last && w_y_last;

endmodule

`default_nettype wire

// File: rtl/viz_frame_scheduler.sv
// ----------------------------------------------------------------------------
// viz_frame_scheduler : snapshots band amplitudes and raster-redraws the
//                       160x120 bar graph once per frame tick.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module viz_frame_scheduler
  import viz_pkg::*;
#(
  parameter int NUM_BANDS = 6,
  parameter int AMP_W     = 4,
  parameter int BAR_W     = 24,
  parameter int SCALE     = 7
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  viz_frame_scheduler_if.slave   bus
);

  localparam int c_h_w      = AMP_W + 3;
  localparam int c_band_w   = $clog2((SCREEN_W - 1) / BAR_W + 1);
  localparam int c_cmp_w    = (c_h_w > Y_W) ? c_h_w : Y_W;
  localparam int c_xc_w     = X_W + 8;
  localparam int c_lit_cols = NUM_BANDS * BAR_W;

  state_t r_state;
  state_t w_next_state;

  logic [NUM_BANDS*AMP_W-1:0] r_snap;
  logic [c_h_w-1:0]           w_h [NUM_BANDS];
  logic [c_h_w-1:0]           r_h [NUM_BANDS];
  logic [c_h_w-1:0]           w_h_sel;

  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic [c_band_w-1:0] w_band;
  logic                w_last_pixel;
  logic                w_cnt_en;
  logic                w_cnt_clr;

  logic [Y_W-1:0]      w_rev;
  logic                w_lit;
  logic [COLOUR_W-1:0] w_pix_colour;

  logic                w_plot_next;
  logic                w_busy_next;
  logic                w_done_next;
  logic [X_W-1:0]      w_x_next;
  logic [Y_W-1:0]      w_y_next;
  logic [COLOUR_W-1:0] w_colour_next;

  logic                r_plot;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_busy;
  logic                r_done;
  logic                r_last;

  generate
    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      logic [AMP_W-1:0] w_amp;
      assign w_amp = r_snap[b*AMP_W +: AMP_W];
      if (SCALE == 7) begin : g_scale7
        assign w_h[b] = (c_h_w'(w_amp) << 3) - c_h_w'(w_amp);
      end else begin : g_mult
        assign w_h[b] = c_h_w'(w_amp * SCALE);
      end
    end
  endgenerate

  // Counter leads the output registers by one pixel so colour is registered
  // alongside x/y; it is parked at (0,0) while ARMED.
  raster_scan_counter #(
    .BAR_W  (BAR_W),
    .BAND_W (c_band_w)
  ) u_scan (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (w_cnt_en),
    .clear      (w_cnt_clr),
    .x          (w_x),
    .y          (w_y),
    .band_idx   (w_band),
    .last_pixel (w_last_pixel)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start)        w_next_state = ARMED;
      ARMED:   if (bus.sample_valid) w_next_state = LATCH;
      LATCH:                         w_next_state = DRAW;
      DRAW:    if (r_last)           w_next_state = HOLD;
      HOLD:    if (bus.frame_tick)   w_next_state = ARMED;
      default:                       w_next_state = IDLE;
    endcase
  end

  // Heights are only registered at the end of LATCH, so the first pixel
  // computed during LATCH reads them straight from the snapshot.
  always_comb begin
    w_h_sel = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (w_band == c_band_w'(b)) begin
        w_h_sel = (r_state == LATCH) ? w_h[b] : r_h[b];
      end
    end
  end

  always_comb begin
    w_cnt_en      = (r_state == LATCH) || (r_state == DRAW);
    w_cnt_clr     = (r_state == ARMED);
    w_rev         = Y_W'(SCREEN_H - 1) - w_y;
    w_lit         = (c_xc_w'(w_x) < c_xc_w'(c_lit_cols)) &&
                    (c_cmp_w'(w_rev) < c_cmp_w'(w_h_sel));
    w_pix_colour  = w_lit ? (COLOUR_W'(w_band) + PALETTE_BASE) : BLACK;
    w_plot_next   = (w_next_state == DRAW);
    w_busy_next   = (w_next_state == LATCH) || (w_next_state == DRAW);
    w_done_next   = (r_state == DRAW) && (w_next_state == HOLD);
    w_x_next      = w_plot_next ? w_x : '0;
    w_y_next      = w_plot_next ? w_y : '0;
    w_colour_next = w_plot_next ? w_pix_colour : BLACK;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= BLACK;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_last   <= 1'b0;
      r_snap   <= '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        r_h[b] <= '0;
      end
    end else begin
      r_plot   <= w_plot_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_colour <= w_colour_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_last   <= w_plot_next && w_last_pixel;
      if ((r_state == ARMED) && bus.sample_valid) begin
        r_snap <= bus.amp_freq;
      end
      if (r_state == LATCH) begin
        r_h <= w_h;
      end
    end
  end

  assign bus.plot       = r_plot;
  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.colour     = r_colour;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_viz_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_viz_frame_scheduler : directed stimulus with a pixel scoreboard for the
//                          bar-graph frame scheduler.          Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_viz_frame_scheduler;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_miss;
  int   n_plots;
  int   cyc;
  pix_t q[$];

  viz_frame_scheduler_if #(.NUM_BANDS(6), .AMP_W(4)) bus ();

  viz_frame_scheduler #(
    .NUM_BANDS (6),
    .AMP_W     (4),
    .BAR_W     (24),
    .SCALE     (7)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Independent reference image: bar b spans columns 24b..24b+23.
  function automatic logic [2:0] exp_col(input logic [23:0] amp, input int x, input int y);
    int b;
    int h;
    if (x >= 144) return 3'd0;
    b = x / 24;
    h = int'((amp >> (4 * b)) & 24'hF) * 7;
    return ((119 - y) < h) ? 3'(b + 1) : 3'd0;
  endfunction

  task automatic push_frame(input logic [23:0] amp);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        q.push_back('{x: 8'(xx), y: 7'(yy), c: exp_col(amp, xx, yy)});
  endtask

  // Monitor: pops the scoreboard on every plot and checks frame_done placement.
  pix_t e;
  logic p_plot;
  logic [7:0] p_x;
  logic [6:0] p_y;
  logic exp_done;
  initial begin
    p_plot = 1'b0;
    p_x = '0;
    p_y = '0;
  end
  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      n_plots++;
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_plot: got plot at x=%0d y=%0d, required no plot", bus.x, bus.y);
      end else begin
        e = q.pop_front();
        chk("pixel{busy,x,y,colour}", 32'({bus.busy, bus.x, bus.y, bus.colour}),
            32'({1'b1, e.x, e.y, e.c}));
      end
    end
    exp_done = p_plot && (p_x == 8'd159) && (p_y == 7'd119);
    if (bus.frame_done || exp_done) chk("frame_done_place", 32'(bus.frame_done), 32'(exp_done));
    p_plot = bus.plot;
    p_x    = bus.x;
    p_y    = bus.y;
  end

  task automatic run_frame(input logic [23:0] amp, input bit mid_sample, input bit tick_on_entry);
    int  t0;
    bit  got;
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.amp_freq     = amp;
    push_frame(amp);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    chk("latch_busy", 32'(bus.busy), 32'd1);
    chk("latch_plot", 32'(bus.plot), 32'd0);
    @(negedge clk);
    chk("first_plot", 32'(bus.plot), 32'd1);
    t0 = cyc;
    if (mid_sample) begin
      repeat (3000) @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.amp_freq     = 24'h123456;
      @(negedge clk);
      bus.sample_valid = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", 32'(cyc - t0), 32'd19200);
    chk("done_plot", 32'(bus.plot), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
    if (tick_on_entry) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  int plots0;
  initial begin
    n_vec = 0;
    n_miss = 0;
    n_plots = 0;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.amp_freq = '0;
    bus.frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_colour", 32'(bus.colour), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Sample while IDLE is ignored.
    bus.sample_valid = 1'b1;
    bus.amp_freq = 24'hFFFFFF;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    // Partial frame aborted by reset near pixel 5000.
    bus.sample_valid = 1'b1;
    bus.amp_freq = 24'h5A3C96;
    push_frame(24'h5A3C96);
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    for (int k = 0; k < 20000 && q.size() > 14200; k++) @(negedge clk);
    chk("partial_progress", 32'(q.size() <= 14200), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_plot", 32'(bus.plot), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_xy", 32'({bus.x, bus.y}), 32'd0);
    chk("midrst_colour", 32'(bus.colour), 32'd0);
    q.delete();
    resetn = 1'b1;

    // No start after reset: sample yields nothing.
    plots0 = n_plots;
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.amp_freq = 24'hFFFFFF;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("nostart_plots", 32'(n_plots - plots0), 32'd0);
    chk("nostart_busy", 32'(bus.busy), 32'd0);

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    run_frame(24'h000000, 1'b0, 1'b1);
    run_frame(24'hFFFFFF, 1'b1, 1'b0);

    // HOLD: lone sample dropped, then sample+tick re-arms without LATCH.
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.amp_freq = 24'hABCDEF;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_drop_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.frame_tick = 1'b1;
    bus.amp_freq = 24'h777777;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    bus.frame_tick = 1'b0;
    @(negedge clk);
    chk("svtick_no_latch", 32'(bus.busy), 32'd0);
    chk("svtick_no_plot", 32'(bus.plot), 32'd0);

    run_frame(24'hF00001, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/viz_frame_scheduler.md
# viz_frame_scheduler

Sequences redraws of the bar-graph frame buffer from the filter's packed band amplitudes. It sits between `filterInput` (amplitude source) and the 160x120 pixel-plot port of the VGA adapter inside `visualOutput`. On each accepted sample it snapshots the amplitudes, then raster-sweeps every pixel once, emitting one plot per cycle. It then holds until the next frame tick, which throttles redraws to the display rate.

## Interface
- `NUM_BANDS`, default 6: number of bars; amplitude vector width is NUM_BANDS*AMP_W.
- `AMP_W`, default 4: bits per band amplitude, unsigned.
- `BAR_W`, default 24: bar width in pixels; columns at or beyond NUM_BANDS*BAR_W are always black.
- `SCALE`, default 7: bar height in pixels per amplitude LSB; max height 15*7 = 105 < 120.
- `clk`, in, 1: system clock (CLOCK_50). One clock; everything is synchronous to it.
- `resetn`, in, 1: synchronous, active-low reset.
- `start`, in, 1: level/pulse; arms the scheduler from IDLE.
- `sample_valid`, in, 1: one-cycle strobe; `amp_freq` is valid in that cycle.
- `amp_freq`, in, NUM_BANDS*AMP_W: packed amplitudes; band 0 in the LSBs.
- `frame_tick`, in, 1: one-cycle strobe at VGA vertical blank.
- `plot`, out, 1: pixel write enable.
- `x`, out, 8: pixel column, 0..159.
- `y`, out, 7: pixel row, 0..119; row 0 is the top.
- `colour`, out, 3: pixel colour.
- `busy`, out, 1: high in LATCH and DRAW.
- `frame_done`, out, 1: one-cycle pulse after the last pixel.

## Operation
- States: IDLE, ARMED, LATCH, DRAW, HOLD.
- IDLE: moves to ARMED when `start`=1. `start` is ignored in every other state.
- ARMED: moves to LATCH in the cycle `sample_valid`=1. In that same cycle `amp_freq` is registered into a snapshot.
- LATCH: lasts 1 cycle. Computes a height per band, h[b] = amp[b]*SCALE. Implement as (amp<<3)-amp when SCALE=7, otherwise a generic multiply. Height width is AMP_W+3 bits, no saturation needed. Sets x=0 and y=0. Next state is DRAW.
- DRAW: sweeps x inner (0..159) and y outer (0..119), one pixel per cycle, with `plot`=1 throughout.
  - Band index is b = x / BAR_W; implement it as a column counter that resets every BAR_W columns, not a divider.
  - The pixel is lit iff x < NUM_BANDS*BAR_W and (119 - y) < h[b].
  - Lit colour is b+1 (band 0 = 3'b001 … band 5 = 3'b110). Unlit colour is 3'b000.
  - After pixel (159,119), DRAW moves to HOLD and `frame_done` pulses.
- HOLD: `plot`=0. Moves to ARMED on `frame_tick`=1.
  - A `frame_tick` that occurs in the same cycle as the entry into HOLD counts.
  - `frame_tick` is ignored in all other states.
- `sample_valid` in LATCH, DRAW or HOLD is dropped; the snapshot stays stable through the whole frame. Only the first sample after re-arming is used.
- Simultaneous `sample_valid` and `frame_tick` in HOLD: go to ARMED only; the sample is dropped.
- Reset (`resetn`=0 at a clock edge), including mid-DRAW, takes effect at that edge: state=IDLE, all outputs 0, snapshot cleared. No partial-frame completion.

## Timing
- Reset values: `plot`=0, `x`=0, `y`=0, `colour`=0, `busy`=0, `frame_done`=0, state=IDLE.
- All outputs are registered. `x`, `y` and `colour` are coherent with `plot` in the same cycle.
- Latency: with `sample_valid` at cycle T, LATCH is at T+1 and the first plot (0,0) is at T+2. The last plot (159,119) is at T+2+19199. `frame_done` is high at T+19202, the first cycle in HOLD, with `plot`=0.
- `busy` is high from T+1 through T+19201 inclusive.
- There is no backpressure: the adapter accepts one plot per cycle.

## Structure
- Package `viz_pkg` holds:
  - SCREEN_W=160 and SCREEN_H=120;
  - the state enum (IDLE, ARMED, LATCH, DRAW, HOLD);
  - the colour constants (BLACK, palette base);
  - the x/y widths.
- Sub-module `raster_scan_counter`: x/y counters plus band column counter, with `enable`, `clear`, `last_pixel` and `band_idx` outputs. The FSM, snapshot, height registers and pixel compare stay in the top.

## Test plan
- Reset, `start`, then `sample_valid` with amp_freq=24'h000000 -> 19200 plots, all colour 0; `frame_done` exactly 19200 cycles after the first plot.
- amp_freq=24'hFFFFFF -> bars occupy x 0..143 and y 15..119. Colours 1..6 per 24-column group; x 144..159 is black; y 0..14 is black.
- amp band0=1, band5=15, others 0 -> column 0 is lit at y=113..119 only (h=7) in colour 1. Column 120 is lit at y=15..119 in colour 6.
- `sample_valid` with different data mid-DRAW and in HOLD -> ignored; the frame image is unchanged, and the next frame uses the first sample after the `frame_tick`.
- `resetn`=0 at pixel ≈5000 -> next cycle `plot`=0 and state IDLE. `sample_valid` without `start` yields no plots; `start` then `sample_valid` yields a full 19200-pixel frame.
- `frame_tick` on the HOLD-entry cycle -> ARMED on the next cycle. `sample_valid`+`frame_tick` together in HOLD -> ARMED and no LATCH.
